// File: rtl/id_ex_register_if.sv
// ID/EX pipeline boundary bundle: ID-side controls/operands in, EX-side registered copies out.
interface id_ex_register_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_stall_EX;
  logic                  i_flush_EX;
  logic                  i_valid_ID;
  logic                  i_jump_ID;
  logic                  i_branch_ID;
  logic                  i_reg_write_ID;
  logic                  i_mem_write_ID;
  logic                  i_alu_src_ID;
  logic                  i_addr_src_ID;
  logic                  i_fence_ID;
  logic [1:0]            i_result_src_ID;
  logic [2:0]            i_alu_op_ID;
  logic [2:0]            i_funct_3_ID;
  logic                  i_funct_7_5_ID;
  logic [DATA_WIDTH-1:0] i_rd1_ID;
  logic [DATA_WIDTH-1:0] i_rd2_ID;
  logic [DATA_WIDTH-1:0] i_pc_ID;
  logic [DATA_WIDTH-1:0] i_pc_plus4_ID;
  logic [DATA_WIDTH-1:0] i_imm_ext_ID;
  logic [4:0]            i_rs1_ID;
  logic [4:0]            i_rs2_ID;
  logic [4:0]            i_rd_ID;

  logic                  o_valid_EX;
  logic                  o_jump_EX;
  logic                  o_branch_EX;
  logic                  o_reg_write_EX;
  logic                  o_mem_write_EX;
  logic                  o_alu_src_EX;
  logic                  o_addr_src_EX;
  logic                  o_fence_EX;
  logic [1:0]            o_result_src_EX;
  logic [2:0]            o_alu_op_EX;
  logic [2:0]            o_funct_3_EX;
  logic                  o_funct_7_5_EX;
  logic [DATA_WIDTH-1:0] o_rd1_EX;
  logic [DATA_WIDTH-1:0] o_rd2_EX;
  logic [DATA_WIDTH-1:0] o_pc_EX;
  logic [DATA_WIDTH-1:0] o_pc_plus4_EX;
  logic [DATA_WIDTH-1:0] o_imm_ext_EX;
  logic [4:0]            o_rs1_EX;
  logic [4:0]            o_rs2_EX;
  logic [4:0]            o_rd_EX;
  logic                  o_fence_stall;

  modport master (
    output i_stall_EX, i_flush_EX, i_valid_ID, i_jump_ID, i_branch_ID, i_reg_write_ID,
           i_mem_write_ID, i_alu_src_ID, i_addr_src_ID, i_fence_ID, i_result_src_ID,
           i_alu_op_ID, i_funct_3_ID, i_funct_7_5_ID, i_rd1_ID, i_rd2_ID, i_pc_ID,
           i_pc_plus4_ID, i_imm_ext_ID, i_rs1_ID, i_rs2_ID, i_rd_ID,
    input  o_valid_EX, o_jump_EX, o_branch_EX, o_reg_write_EX, o_mem_write_EX,
           o_alu_src_EX, o_addr_src_EX, o_fence_EX, o_result_src_EX, o_alu_op_EX,
           o_funct_3_EX, o_funct_7_5_EX, o_rd1_EX, o_rd2_EX, o_pc_EX, o_pc_plus4_EX,
           o_imm_ext_EX, o_rs1_EX, o_rs2_EX, o_rd_EX, o_fence_stall
  );

  modport slave (
    input  i_stall_EX, i_flush_EX, i_valid_ID, i_jump_ID, i_branch_ID, i_reg_write_ID,
           i_mem_write_ID, i_alu_src_ID, i_addr_src_ID, i_fence_ID, i_result_src_ID,
           i_alu_op_ID, i_funct_3_ID, i_funct_7_5_ID, i_rd1_ID, i_rd2_ID, i_pc_ID,
           i_pc_plus4_ID, i_imm_ext_ID, i_rs1_ID, i_rs2_ID, i_rd_ID,
    output o_valid_EX, o_jump_EX, o_branch_EX, o_reg_write_EX, o_mem_write_EX,
           o_alu_src_EX, o_addr_src_EX, o_fence_EX, o_result_src_EX, o_alu_op_EX,
           o_funct_3_EX, o_funct_7_5_EX, o_rd1_EX, o_rd2_EX, o_pc_EX, o_pc_plus4_EX,
           o_imm_ext_EX, o_rs1_EX, o_rs2_EX, o_rd_EX, o_fence_stall
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with stall/flush and a FENCE drain counter that
// injects bubbles into EX and holds the front end while memory ops settle.
module id_ex_register #(
  parameter int DATA_WIDTH  = 32,
  parameter int FENCE_DRAIN = 3
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_register_if.slave bus
);
  typedef struct packed {
    logic                  valid;
    logic                  jump;
    logic                  branch;
    logic                  reg_write;
    logic                  mem_write;
    logic                  alu_src;
    logic                  addr_src;
    logic                  fence;
    logic [1:0]            result_src;
    logic [2:0]            alu_op;
    logic [2:0]            funct_3;
    logic                  funct_7_5;
    logic [DATA_WIDTH-1:0] rd1;
    logic [DATA_WIDTH-1:0] rd2;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
  } ex_t;

  // A bubble is all-zero except the ALU op, which idles as add.
  function automatic ex_t bubble_f();
    ex_t r;
    r        = '0;
    r.alu_op = 3'b010;
    return r;
  endfunction

  ex_t        ex_q, ex_d, id_s;
  logic [2:0] cnt_q, cnt_d;
  logic       fence_stall_q;

  assign id_s.valid      = bus.i_valid_ID;
  assign id_s.jump       = bus.i_jump_ID;
  assign id_s.branch     = bus.i_branch_ID;
  assign id_s.reg_write  = bus.i_reg_write_ID;
  assign id_s.mem_write  = bus.i_mem_write_ID;
  assign id_s.alu_src    = bus.i_alu_src_ID;
  assign id_s.addr_src   = bus.i_addr_src_ID;
  assign id_s.fence      = bus.i_fence_ID;
  assign id_s.result_src = bus.i_result_src_ID;
  assign id_s.alu_op     = bus.i_alu_op_ID;
  assign id_s.funct_3    = bus.i_funct_3_ID;
  assign id_s.funct_7_5  = bus.i_funct_7_5_ID;
  assign id_s.rd1        = bus.i_rd1_ID;
  assign id_s.rd2        = bus.i_rd2_ID;
  assign id_s.pc         = bus.i_pc_ID;
  assign id_s.pc_plus4   = bus.i_pc_plus4_ID;
  assign id_s.imm_ext    = bus.i_imm_ext_ID;
  assign id_s.rs1        = bus.i_rs1_ID;
  assign id_s.rs2        = bus.i_rs2_ID;
  assign id_s.rd         = bus.i_rd_ID;

  always_comb begin
    ex_d  = ex_q;
    cnt_d = cnt_q;
    if (bus.i_flush_EX) begin
      ex_d = bubble_f();
    end else if (cnt_q != 3'd0) begin
      ex_d = bubble_f();
    end else if (bus.i_stall_EX) begin
      ex_d = ex_q;
    end else if (!bus.i_valid_ID) begin
      ex_d = bubble_f();
    end else begin
      ex_d = id_s;
      if (bus.i_fence_ID) begin
        cnt_d = 3'(FENCE_DRAIN);
      end
    end
    // Draining ticks independently of flush; only a stall freezes it.
    if (cnt_q != 3'd0 && !bus.i_stall_EX) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q          <= bubble_f();
      cnt_q         <= 3'd0;
      fence_stall_q <= 1'b0;
    end else begin
      ex_q          <= ex_d;
      cnt_q         <= cnt_d;
      fence_stall_q <= (cnt_d != 3'd0);
    end
  end

  assign bus.o_valid_EX      = ex_q.valid;
  assign bus.o_jump_EX       = ex_q.jump;
  assign bus.o_branch_EX     = ex_q.branch;
  assign bus.o_reg_write_EX  = ex_q.reg_write;
  assign bus.o_mem_write_EX  = ex_q.mem_write;
  assign bus.o_alu_src_EX    = ex_q.alu_src;
  assign bus.o_addr_src_EX   = ex_q.addr_src;
  assign bus.o_fence_EX      = ex_q.fence;
  assign bus.o_result_src_EX = ex_q.result_src;
  assign bus.o_alu_op_EX     = ex_q.alu_op;
  assign bus.o_funct_3_EX    = ex_q.funct_3;
  assign bus.o_funct_7_5_EX  = ex_q.funct_7_5;
  assign bus.o_rd1_EX        = ex_q.rd1;
  assign bus.o_rd2_EX        = ex_q.rd2;
  assign bus.o_pc_EX         = ex_q.pc;
  assign bus.o_pc_plus4_EX   = ex_q.pc_plus4;
  assign bus.o_imm_ext_EX    = ex_q.imm_ext;
  assign bus.o_rs1_EX        = ex_q.rs1;
  assign bus.o_rs2_EX        = ex_q.rs2;
  assign bus.o_rd_EX         = ex_q.rd;
  assign bus.o_fence_stall   = fence_stall_q;
endmodule
